muldiv_hilo_ctrl: RTL and testbench

- Iterative multiply/divide sequencer that owns the HI/LO register pair for the five-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO requests from the decode stage.
- Runs one operation at a time over WIDTH cycles.
- Raises a stall to the pipeline whenever a request hits a busy unit.
- Supplies HI/LO read data to the write-back mux.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_datapath.sv | 73 +++++++
 rtl/muldiv_hilo_ctrl.sv | 167 ++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// FSM state encoding and the divide-by-zero LO pattern.
package muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_e;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Wide enough for any supported WIDTH; the top slices what it needs.
    localparam int unsigned  MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] DIV0_LO = '1;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift registers and the shared add/subtract step for shift-add multiply
// (mode=0) and restoring divide (mode=1) on unsigned magnitudes.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] a_val,
    input  logic [WIDTH-1:0] b_val,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q,  b_d;
    logic [WIDTH:0]   lhs, rhs, sum;
    logic             fits;

    // One adder: multiply adds the multiplicand when the low bit is set,
    // divide subtracts the divisor from the left-shifted partial remainder.
    always_comb begin
        if (mode == MODE_DIV) begin
            lhs = {hi_q, lo_q[WIDTH-1]};
            rhs = ~{1'b0, b_q};
        end else begin
            lhs = {1'b0, hi_q};
            rhs = lo_q[0] ? {1'b0, b_q} : '0;
        end
        sum  = lhs + rhs + {{WIDTH{1'b0}}, mode};
        fits = ~sum[WIDTH];
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        if (load) begin
            hi_d = '0;
            lo_d = a_val;
            b_d  = b_val;
        end else if (step) begin
            if (mode == MODE_DIV) begin
                hi_d = fits ? sum[WIDTH-1:0] : lhs[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], fits};
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Iterative MULT/DIV sequencer owning HI/LO; stalls decode while busy and
// provides MFHI/MFLO read data to write-back.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_mult,
    input  logic             op_multu,
    input  logic             op_div,
    input  logic             op_divu,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             mfhi,
    input  logic             mflo,
    input  logic             cancel,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             stall
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             mode_q, mode_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             dz_q, dz_d;

    logic             any_op, start_signed, start_div, rs_neg, rt_neg, dz_start;
    logic             dp_load, dp_step;
    logic [WIDTH-1:0] dp_a, dp_b, acc_hi, acc_lo;
    logic [2*WIDTH-1:0] prod;

    assign any_op = op_mult | op_multu | op_div | op_divu;

    always_comb begin
        start_signed = 1'b0;
        start_div    = 1'b1;
        if (op_mult) begin
            start_signed = 1'b1;
            start_div    = 1'b0;
        end else if (op_multu) begin
            start_div    = 1'b0;
        end else if (op_div) begin
            start_signed = 1'b1;
        end
        rs_neg   = start_signed & rs_val[WIDTH-1];
        rt_neg   = start_signed & rt_val[WIDTH-1];
        dz_start = start_div & (rt_val == '0);
        // Divide by zero parks the raw dividend in the datapath for HI.
        dp_a     = (rs_neg && !dz_start) ? -rs_val : rs_val;
        dp_b     = rt_neg ? -rt_val : rt_val;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mode_d   = mode_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        prod     = {acc_hi, acc_lo};
        if (neg_lo_q) begin
            prod = -prod;
        end

        if (cancel) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (any_op) begin
                        dp_load  = 1'b1;
                        cnt_d    = '0;
                        mode_d   = start_div ? MODE_DIV : MODE_MUL;
                        neg_lo_d = rs_neg ^ rt_neg;
                        neg_hi_d = rs_neg;
                        dz_d     = dz_start;
                        if (dz_start) begin
                            state_d = ST_FIX;
                        end else begin
                            state_d = start_div ? ST_DIV : ST_MUL;
                        end
                    end else begin
                        if (mthi) hi_d = rs_val;
                        if (mtlo) lo_d = rs_val;
                    end
                end
                ST_MUL, ST_DIV: begin
                    dp_step = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_d = ST_IDLE;
                    if (dz_q) begin
                        hi_d = acc_lo;
                        lo_d = DIV0_LO[WIDTH-1:0];
                    end else if (mode_q == MODE_DIV) begin
                        hi_d = neg_hi_q ? -acc_hi : acc_hi;
                        lo_d = neg_lo_q ? -acc_lo : acc_lo;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            mode_q   <= MODE_MUL;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mode_q   <= mode_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk    (clk),
        .rst    (rst),
        .load   (dp_load),
        .step   (dp_step),
        .mode   (mode_q),
        .a_val  (dp_a),
        .b_val  (dp_b),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo)
    );

    assign busy  = (state_q != ST_IDLE);
    assign stall = busy & (any_op | mthi | mtlo | mfhi | mflo);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign rdata = mfhi ? hi_q : lo_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl with hand-computed HI/LO results.
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_mult = 0, op_multu = 0, op_div = 0, op_divu = 0;
    logic        mthi = 0, mtlo = 0, mfhi = 0, mflo = 0, cancel = 0;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic [31:0] hi, lo, rdata;
    logic        busy, stall;

    int total = 0;
    int bad   = 0;

    muldiv_hilo_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
        .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo), .cancel(cancel),
        .rs_val(rs_val), .rt_val(rt_val),
        .hi(hi), .lo(lo), .rdata(rdata), .busy(busy), .stall(stall)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        assert ($onehot0({op_mult, op_multu, op_div, op_divu}))
        else begin
            bad++;
            $error("FAIL onehot ops=%b", {op_mult, op_multu, op_div, op_divu});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // kind: 0 mult, 1 multu, 2 div, 3 divu. Returns cycles spent busy.
    task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b,
                          output int ncyc);
        rs_val = a;
        rt_val = b;
        op_mult  = (kind == 0);
        op_multu = (kind == 1);
        op_div   = (kind == 2);
        op_divu  = (kind == 3);
        tick();
        op_mult = 0; op_multu = 0; op_div = 0; op_divu = 0;
        ncyc = 0;
        while (busy && ncyc < 200) begin
            tick();
            ncyc++;
        end
    endtask

    int n;
    int stall_bad;

    initial begin
        mflo = 1;
        #2;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        tick();
        rst = 0;
        mflo = 0;
        tick();

        // Moves in idle
        rs_val = 32'h0000ABCD; mtlo = 1; tick(); mtlo = 0;
        chk("mtlo", lo, 32'h0000ABCD);
        rs_val = 32'h00001111; mthi = 1; tick(); mthi = 0;
        chk("mthi", hi, 32'h00001111);
        mfhi = 1; #1;
        chk("mfhi_rdata", rdata, 32'h00001111);
        chk("mfhi_stall", {31'b0, stall}, 32'h0);
        mfhi = 0;

        run_op(0, 32'd7, 32'hFFFFFFFD, n);
        chk("mult_cycles", n, 32'd33);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        run_op(1, 32'hFFFFFFFF, 32'd2, n);
        chk("multu_hi", hi, 32'h00000001);
        chk("multu_lo", lo, 32'hFFFFFFFE);

        run_op(2, 32'hFFFFFFF9, 32'd2, n);
        chk("div_cycles", n, 32'd33);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        run_op(3, 32'd100, 32'd7, n);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        run_op(2, 32'd7, 32'hFFFFFFFE, n);
        chk("div_negd_lo", lo, 32'hFFFFFFFD);
        chk("div_negd_hi", hi, 32'd1);

        run_op(3, 32'h00001234, 32'd0, n);
        chk("dz_cycles", n, 32'd1);
        chk("dz_hi", hi, 32'h00001234);
        chk("dz_lo", lo, 32'hFFFFFFFF);

        // mflo held across a multiply: stalls every busy cycle
        rs_val = 32'd3; rt_val = 32'd4; op_mult = 1;
        tick();
        op_mult = 0; mflo = 1;
        n = 0; stall_bad = 0;
        while (busy && n < 200) begin
            if (stall !== 1'b1) stall_bad++;
            tick();
            n++;
        end
        chk("haz_stall_bad", stall_bad, 32'd0);
        chk("haz_cycles", n, 32'd33);
        chk("haz_stall_idle", {31'b0, stall}, 32'h0);
        chk("haz_rdata", rdata, 32'd12);
        mflo = 0;

        // mthi presented while busy is held off until completion
        rs_val = 32'd2; rt_val = 32'd3; op_multu = 1;
        tick();
        op_multu = 0; mthi = 1; rs_val = 32'd5;
        #1;
        chk("mthi_stall", {31'b0, stall}, 32'h1);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("mthi_res_hi", hi, 32'd0);
        chk("mthi_res_lo", lo, 32'd6);
        tick();
        mthi = 0;
        chk("mthi_late_hi", hi, 32'd5);

        // Cancel at iteration 10
        rs_val = 32'd9; rt_val = 32'd9; op_mult = 1;
        tick();
        op_mult = 0;
        repeat (10) tick();
        chk("cancel_busy_b", {31'b0, busy}, 32'h1);
        cancel = 1; tick(); cancel = 0;
        chk("cancel_busy", {31'b0, busy}, 32'h0);
        repeat (40) tick();
        chk("cancel_hi", hi, 32'd5);
        chk("cancel_lo", lo, 32'd6);

        // Cancel drops a same-cycle start in idle
        rs_val = 32'd9; rt_val = 32'd9; op_mult = 1; cancel = 1;
        tick();
        op_mult = 0; cancel = 0;
        chk("cancel_op_busy", {31'b0, busy}, 32'h0);

        // Reset at iteration 20
        rs_val = 32'd1000; rt_val = 32'd3; op_divu = 1;
        tick();
        op_divu = 0;
        repeat (20) tick();
        rst = 1;
        #1;
        chk("rstmid_hi", hi, 32'h0);
        chk("rstmid_lo", lo, 32'h0);
        chk("rstmid_busy", {31'b0, busy}, 32'h0);
        tick();
        rst = 0;
        repeat (40) tick();
        chk("rstmid_hi2", hi, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
